// File: rtl/float_format_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_format_pkg
// Description : Shared float-format helpers for the serial float blocks:
//               field widths and bias per float width, result flag bit
//               positions, and the common serial FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package float_format_pkg;

    // Bit positions inside the 3-bit flags vector {invalid, overflow, inexact}
    localparam int FLAG_INVALID  = 2;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INEXACT  = 0;

    // Serial FSM state encoding, shared by the serial float operators
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_shift  = 3'd2;
    localparam logic [2:0] c_st_pack   = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = c_st_idle,
        ST_DECODE = c_st_decode,
        ST_SHIFT  = c_st_shift,
        ST_PACK   = c_st_pack,
        ST_DONE   = c_st_done
    } state_t;

    // Exponent field width for a given float width (16/32/64)
    function automatic int exp_size(input int fs);
        case (fs)
            16:      return 5;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

    // Stored mantissa (fraction) width for a given float width
    function automatic int mant_size(input int fs);
        case (fs)
            16:      return 10;
            64:      return 52;
            default: return 23;
        endcase
    endfunction

    // Exponent bias: 2^(exp_size-1) - 1
    function automatic int bias(input int fs);
        return (1 << (exp_size(fs) - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/float_to_int_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : float_to_int_serial_if
// Description : Input/output valid-ready bundle of the float-to-int converter.
//               master = producer/consumer side, slave = converter side.
// Ports       : in_valid/in_ready/float_in   - float input handshake
//               out_valid/out_ready          - result handshake
//               int_out, flags               - result {invalid,overflow,inexact}
// Revision    : 1.0 - initial release
// ============================================================================
interface float_to_int_serial_if #(
    parameter int INT_SIZE   = 16,
    parameter int FLOAT_SIZE = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [FLOAT_SIZE-1:0] float_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [INT_SIZE-1:0]   int_out;
    logic [2:0]            flags;

    modport master (
        output in_valid, float_in, out_ready,
        input  in_ready, out_valid, int_out, flags
    );

    modport slave (
        input  in_valid, float_in, out_ready,
        output in_ready, out_valid, int_out, flags
    );
endinterface
`default_nettype wire

// File: rtl/float_unpack.sv
`default_nettype none
// ============================================================================
// Module      : float_unpack
// Description : Combinational field split and classification of an
//               IEEE-754-style float.
// Ports       : i_float       - {sign, exponent, mantissa}
//               o_sign        - sign bit
//               o_mant        - stored mantissa (no hidden bit)
//               o_is_zero     - exponent 0, mantissa 0
//               o_is_denorm   - exponent 0, mantissa nonzero
//               o_is_inf      - exponent all ones, mantissa 0
//               o_is_nan      - exponent all ones, mantissa nonzero
//               o_exp_unb     - signed unbiased exponent (exp - bias)
// Revision    : 1.0 - initial release
// ============================================================================
module float_unpack
    import float_format_pkg::*;
#(
    parameter int FLOAT_SIZE = 32,
    parameter int EXP_W      = exp_size(FLOAT_SIZE),
    parameter int MANT_W     = mant_size(FLOAT_SIZE)
) (
    input  wire logic [FLOAT_SIZE-1:0]   i_float,
    output logic                         o_sign,
    output logic [MANT_W-1:0]            o_mant,
    output logic                         o_is_zero,
    output logic                         o_is_denorm,
    output logic                         o_is_inf,
    output logic                         o_is_nan,
    output logic signed [EXP_W+1:0]      o_exp_unb
);
    // Two extra bits keep exp - bias representable for every encoding
    localparam logic signed [EXP_W+1:0] c_bias = (EXP_W+2)'(bias(FLOAT_SIZE));

    logic [EXP_W-1:0] w_exp;
    logic             w_exp_zero;
    logic             w_exp_ones;
    logic             w_mant_nz;

    assign o_sign      = i_float[FLOAT_SIZE-1];
    assign w_exp       = i_float[FLOAT_SIZE-2 -: EXP_W];
    assign o_mant      = i_float[MANT_W-1:0];

    assign w_exp_zero  = (w_exp == '0);
    assign w_exp_ones  = &w_exp;
    assign w_mant_nz   = |o_mant;

    assign o_is_zero   = w_exp_zero & ~w_mant_nz;
    assign o_is_denorm = w_exp_zero &  w_mant_nz;
    assign o_is_inf    = w_exp_ones & ~w_mant_nz;
    assign o_is_nan    = w_exp_ones &  w_mant_nz;
    assign o_exp_unb   = $signed({2'b00, w_exp}) - c_bias;
endmodule
`default_nettype wire

// File: rtl/float_to_int_serial.sv
`default_nettype none
// ============================================================================
// Module      : float_to_int_serial
// Description : Sequential float -> saturated two's-complement integer.
//               The mantissa is aligned by a one-bit-per-cycle shifter.
//               Only one conversion is in flight at a time.
// Ports       : clk    - clock, rising edge
//               reset  - synchronous, active-high
//               bus    - float_to_int_serial_if.slave (in/out handshakes,
//                        int_out and flags {invalid, overflow, inexact})
// Options     : FLOAT_TO_INT_ROUND_NEAREST_EN - round half to even in PACK;
//               when undefined the result truncates toward zero.
// Revision    : 1.0 - initial release
// ============================================================================
module float_to_int_serial
    import float_format_pkg::*;
#(
    parameter int INT_SIZE   = 16,
    parameter int FLOAT_SIZE = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    float_to_int_serial_if.slave  bus
);
    localparam int EXP_W  = exp_size(FLOAT_SIZE);
    localparam int MANT_W = mant_size(FLOAT_SIZE);
    // Accumulator holds {1, mantissa} or a left-aligned integer, plus a guard
    localparam int ACC_W  = (((MANT_W + 1) > INT_SIZE) ? (MANT_W + 1) : INT_SIZE) + 1;
    localparam int CNT_W  = $clog2(ACC_W + 1) + 1;

    localparam logic signed [EXP_W+1:0] c_e_sat  = (EXP_W+2)'(INT_SIZE - 1);
    localparam logic signed [EXP_W+1:0] c_e_mant = (EXP_W+2)'(MANT_W);
    localparam logic [INT_SIZE-1:0]     c_int_max = {1'b0, {(INT_SIZE-1){1'b1}}};
    localparam logic [INT_SIZE-1:0]     c_int_min = {1'b1, {(INT_SIZE-1){1'b0}}};

    state_t                   r_state;
    state_t                   w_next_state;
    logic [FLOAT_SIZE-1:0]    r_float;
    logic [ACC_W-1:0]         r_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_dir_right;
    logic                     r_sticky;
    logic [INT_SIZE-1:0]      r_int_out;
    logic [2:0]               r_flags;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    logic                     r_guard;
`endif

    // Classification of the captured float
    logic                     w_sign;
    logic [MANT_W-1:0]        w_mant;
    logic                     w_is_zero;
    logic                     w_is_denorm;
    logic                     w_is_inf;
    logic                     w_is_nan;
    logic signed [EXP_W+1:0]  w_exp_unb;

    float_unpack #(
        .FLOAT_SIZE (FLOAT_SIZE)
    ) u_unpack (
        .i_float     (r_float),
        .o_sign      (w_sign),
        .o_mant      (w_mant),
        .o_is_zero   (w_is_zero),
        .o_is_denorm (w_is_denorm),
        .o_is_inf    (w_is_inf),
        .o_is_nan    (w_is_nan),
        .o_exp_unb   (w_exp_unb)
    );

    // ---------------- DECODE: special cases and shift setup ----------------
    logic                     w_special;
    logic [INT_SIZE-1:0]      w_special_res;
    logic [2:0]               w_special_flags;
    logic                     w_dir_right;
    logic signed [EXP_W+1:0]  w_shift_amt;
    logic [CNT_W-1:0]         w_cnt_init;
    logic [ACC_W-1:0]         w_acc_init;

    always_comb begin
        w_special       = 1'b1;
        w_special_res   = '0;
        w_special_flags = '0;
        if (w_is_nan) begin
            w_special_res                 = c_int_min;
            w_special_flags[FLAG_INVALID] = 1'b1;
        end else if (w_is_inf || (w_exp_unb >= c_e_sat)) begin
            // -2^(INT_SIZE-1) is representable exactly and is not an overflow
            if (w_sign && !w_is_inf && (w_exp_unb == c_e_sat) && (w_mant == '0)) begin
                w_special_res = c_int_min;
            end else begin
                w_special_res                  = w_sign ? c_int_min : c_int_max;
                w_special_flags[FLAG_OVERFLOW] = 1'b1;
            end
        end else if (w_is_zero || w_is_denorm) begin
            w_special_flags[FLAG_INEXACT] = |w_mant;
        end else if (w_exp_unb[EXP_W+1]) begin
            // |value| < 1
            w_special_flags[FLAG_INEXACT] = 1'b1;
        end else begin
            w_special = 1'b0;
        end
    end

    assign w_dir_right = (w_exp_unb < c_e_mant);
    assign w_shift_amt = w_dir_right ? (c_e_mant - w_exp_unb) : (w_exp_unb - c_e_mant);
    assign w_cnt_init  = CNT_W'(w_shift_amt);
    assign w_acc_init  = ACC_W'({1'b1, w_mant});

    // ---------------- PACK: rounding, sign and flags ----------------
    logic [INT_SIZE-1:0]      w_mag;
    logic [INT_SIZE-1:0]      w_pack_res;
    logic [2:0]               w_pack_flags;

    // After alignment the magnitude is below 2^(INT_SIZE-1)
    assign w_mag = r_acc[INT_SIZE-1:0];

`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    logic                     w_round_up;
    logic [INT_SIZE-1:0]      w_mag_rnd;

    assign w_round_up = r_guard & (r_sticky | r_acc[0]);
    assign w_mag_rnd  = w_mag + INT_SIZE'(w_round_up);

    always_comb begin
        w_pack_flags = '0;
        if (!w_sign && w_mag_rnd[INT_SIZE-1]) begin
            // Rounded up to 2^(INT_SIZE-1): not representable when positive
            w_pack_res                  = c_int_max;
            w_pack_flags[FLAG_OVERFLOW] = 1'b1;
        end else begin
            w_pack_res                 = w_sign ? ('0 - w_mag_rnd) : w_mag_rnd;
            w_pack_flags[FLAG_INEXACT] = r_guard | r_sticky;
        end
    end
`else
    always_comb begin
        w_pack_flags               = '0;
        w_pack_res                 = w_sign ? ('0 - w_mag) : w_mag;
        w_pack_flags[FLAG_INEXACT] = r_sticky;
    end
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_special) begin
                    w_next_state = ST_DONE;
                end else if (w_cnt_init == '0) begin
                    w_next_state = ST_PACK;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = ST_PACK;
                end
            end
            ST_PACK: begin
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_float     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_dir_right <= 1'b0;
            r_sticky    <= 1'b0;
            r_int_out   <= '0;
            r_flags     <= '0;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
            r_guard     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_float <= bus.float_in;
                    end
                end
                ST_DECODE: begin
                    r_acc       <= w_acc_init;
                    r_cnt       <= w_cnt_init;
                    r_dir_right <= w_dir_right;
                    r_sticky    <= 1'b0;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
                    r_guard     <= 1'b0;
`endif
                    if (w_special) begin
                        r_int_out <= w_special_res;
                        r_flags   <= w_special_flags;
                    end
                end
                ST_SHIFT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_dir_right) begin
                        r_acc <= r_acc >> 1;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
                        // Guard holds the most recent lost bit; older ones go to sticky
                        r_guard  <= r_acc[0];
                        r_sticky <= r_sticky | r_guard;
`else
                        r_sticky <= r_sticky | r_acc[0];
`endif
                    end else begin
                        r_acc <= r_acc << 1;
                    end
                end
                ST_PACK: begin
                    r_int_out <= w_pack_res;
                    r_flags   <= w_pack_flags;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.int_out = r_int_out;
    assign bus.flags   = r_flags;
endmodule
`default_nettype wire
